// File: rtl/uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register
// offsets, FSM state encoding, STATUS/CTRL bit positions and a helper that
// packs the STATUS word.
package uart_tx_pkg;

  // Register word offsets from the block base address.
  localparam logic [31:0] OFF_TXDATA = 32'h0000_0000;
  localparam logic [31:0] OFF_STATUS = 32'h0000_0004;
  localparam logic [31:0] OFF_CTRL   = 32'h0000_0008;

  // Transmit FSM encoding.
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  // STATUS bit positions.
  localparam int STAT_FULL   = 0;
  localparam int STAT_EMPTY  = 1;
  localparam int STAT_ACTIVE = 2;
  localparam int STAT_OVF    = 3;
  localparam int STAT_LVL_LO = 4;
  localparam int STAT_LVL_HI = 8;
  localparam int STAT_PARITY = 9;

  // CTRL bit positions.
  localparam int CTRL_ENABLE  = 0;
  localparam int CTRL_CLR_OVF = 1;

  // Packs the STATUS word; every bit not listed reads as zero.
  function automatic logic [31:0] pack_status(
    input logic       full,
    input logic       empty,
    input logic       active,
    input logic       ovf,
    input logic [4:0] level,
    input logic       parity_feat
  );
    logic [31:0] s;
    s                          = '0;
    s[STAT_FULL]               = full;
    s[STAT_EMPTY]              = empty;
    s[STAT_ACTIVE]             = active;
    s[STAT_OVF]                = ovf;
    s[STAT_LVL_HI:STAT_LVL_LO] = level;
    s[STAT_PARITY]             = parity_feat;
    return s;
  endfunction

endpackage

// File: rtl/tx_fifo.sv
// Synchronous FIFO holding bytes waiting for the transmitter. A push while
// full is accepted only when a pop happens in the same cycle. Read data is
// the head entry, valid whenever the FIFO is not empty.
module tx_fifo
  import uart_tx_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Storage array: written on accepted pushes only.
  // NOTE: the data array has no reset; pointers and level define which
  // entries are valid, so resetting them alone discards the contents.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally modulo DEPTH; level tracks occupancy.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter on the MCU data-store bus. Stores to TXDATA
// are queued in tx_fifo and sent LSB-first, 8N1 by default. STATUS is
// returned combinationally for polling loads; CTRL holds enable and a
// write-one overflow clear.
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bit (advertised in STATUS bit9).
module mmio_uart_tx
  import uart_tx_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000,
  parameter int          DEPTH     = 8,
  parameter int          CLK_DIV   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        busy
);

`ifdef UART_TX_PARITY_EN
  localparam logic PARITY_EN = 1'b1;
`else
  localparam logic PARITY_EN = 1'b0;
`endif

  localparam int LW = $clog2(DEPTH) + 1;
  localparam int CW = $clog2(CLK_DIV);

  logic [2:0]    state;
  logic [2:0]    state_next;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          parity_bit;
  logic          enable;
  logic          overflow;

  logic          push_req;
  logic          ctrl_wr;
  logic          baud_done;
  logic          start_ok;
  logic          pop;
  logic [7:0]    fifo_rdata;
  logic          fifo_full;
  logic          fifo_empty;
  logic [LW-1:0] fifo_level;
  logic          unused_wdata_hi;

  // Only the low byte of store data carries anything for this block.
  assign unused_wdata_hi = ^wdata[31:8];

  assign push_req  = we && (addr == BASE_ADDR + OFF_TXDATA);
  assign ctrl_wr   = we && (addr == BASE_ADDR + OFF_CTRL);
  assign baud_done = (baud_cnt == CW'(CLK_DIV - 1));
  assign start_ok  = enable && !fifo_empty;
  // A frame is loaded from IDLE, or straight out of STOP for zero-gap frames.
  assign pop       = start_ok &&
                     ((state == ST_IDLE) || ((state == ST_STOP) && baud_done));

  tx_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_req),
    .pop   (pop),
    .wdata (wdata[7:0]),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // Next-state logic for the frame sequencer.
  // NOTE: state_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (start_ok) state_next = ST_START;
      ST_START:  if (baud_done) state_next = ST_DATA;
      ST_DATA:   if (baud_done && (bit_idx == 3'd7))
                   state_next = PARITY_EN ? ST_PARITY : ST_STOP;
      ST_PARITY: if (baud_done) state_next = ST_STOP;
      ST_STOP:   if (baud_done) state_next = start_ok ? ST_START : ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // FSM state, baud counter and bit index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
    end else begin
      state    <= state_next;
      baud_cnt <= ((state == ST_IDLE) || baud_done) ? '0 : baud_cnt + CW'(1);
      if (pop)
        bit_idx <= '0;
      else if ((state == ST_DATA) && baud_done)
        bit_idx <= bit_idx + 3'd1;
    end
  end

  // Shift register and parity are captured at the pop that starts a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift      <= '0;
      parity_bit <= 1'b0;
    end else if (pop) begin
      shift      <= fifo_rdata;
      parity_bit <= ^fifo_rdata;
    end else if ((state == ST_DATA) && baud_done) begin
      shift      <= shift >> 1;
    end
  end

  // CTRL enable and the sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable   <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (ctrl_wr) enable <= wdata[CTRL_ENABLE];
      if (push_req && fifo_full && !pop)
        overflow <= 1'b1;
      else if (ctrl_wr && wdata[CTRL_CLR_OVF])
        overflow <= 1'b0;
    end
  end

  // Line level is decoded from registered state, so reset forces it high at once.
  always_comb begin
    tx = 1'b1;
    case (state)
      ST_START:  tx = 1'b0;
      ST_DATA:   tx = shift[0];
      ST_PARITY: tx = parity_bit;
      default:   tx = 1'b1;
    endcase
  end

  // Status read port and busy indication.
  always_comb begin
    busy  = (state != ST_IDLE) || !fifo_empty;
    rdata = '0;
    if (addr == BASE_ADDR + OFF_STATUS)
      rdata = pack_status(fifo_full, fifo_empty, state != ST_IDLE, overflow,
                          5'(fifo_level), PARITY_EN);
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx (DEPTH=8, CLK_DIV=4): register table,
// hand-written waveform sequences, randomized stores against a frame-timing
// model, and an asynchronous reset in the middle of a frame.
`timescale 1ns/1ps
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE  = 32'hFFFF_0000;
  localparam int          DEPTH = 8;
  localparam int          CD    = 4;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int          FL = (10 + PAR) * CD;
  localparam logic [31:0] SB = (PAR != 0) ? 32'h0000_0200 : 32'h0;
  localparam logic [31:0] S2 = SB | 32'h2;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        we    = 1'b0;
  logic [31:0] addr  = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic        tx;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mmio_uart_tx #(
    .BASE_ADDR (BASE),
    .DEPTH     (DEPTH),
    .CLK_DIV   (CD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .addr  (addr),
    .wdata (wdata),
    .we    (we),
    .rdata (rdata),
    .tx    (tx),
    .busy  (busy)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] exp_rd;
    logic [31:0] exp_st;
    logic        exp_tx;
  } vec_t;

  typedef struct {
    logic [7:0] b;
    int         s;
    logic       ok;
  } rx_t;

  rx_t rx_q[$];
  bit  mon_en = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_status(output logic [31:0] s);
    we   = 1'b0;
    addr = BASE + 32'h4;
    #1;
    s = rdata;
  endtask

  task automatic push(input logic [31:0] d, output int e);
    addr  = BASE;
    wdata = d;
    we    = 1'b1;
    step();
    e     = cyc - 1;
    we    = 1'b0;
    addr  = BASE + 32'h4;
  endtask

  task automatic write_ctrl(input logic [31:0] d);
    addr  = BASE + 32'h8;
    wdata = d;
    we    = 1'b1;
    step();
    we    = 1'b0;
    addr  = BASE + 32'h4;
  endtask

  task automatic wait_idle(input int limit, input string name);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < limit) begin
      step();
      n++;
    end
    check({name, "_idle"}, 32'(busy), 32'h0);
  endtask

  // Expected line level k cycles into a frame carrying byte b.
  function automatic logic frame_level(input logic [7:0] b, input int k);
    if (k < CD) return 1'b0;
    if (k < 9 * CD) return b[(k - CD) / CD];
    if (PAR != 0 && k < 10 * CD) return ^b;
    return 1'b1;
  endfunction

  // Called in the first cycle of the first frame; checks every cycle.
  task automatic check_wave(input logic [7:0] bytes[$], input string name);
    for (int f = 0; f < bytes.size(); f++) begin
      for (int k = 0; k < FL; k++) begin
        check($sformatf("%s_f%0d_c%0d", name, f, k), 32'(tx), 32'(frame_level(bytes[f], k)));
        if (k == 0 || k == FL - 1)
          check($sformatf("%s_f%0d_busy%0d", name, f, k), 32'(busy), 32'h1);
        step();
      end
    end
  endtask

  // Line receiver: samples each bit in the middle of its period.
  initial begin : monitor
    rx_t        r;
    logic [7:0] b;
    logic       okk;
    forever begin
      step();
      if (mon_en && rst_n === 1'b1 && tx === 1'b0) begin
        r.s = cyc - 1;
        okk = 1'b1;
        repeat (CD / 2) step();
        if (tx !== 1'b0) okk = 1'b0;
        for (int i = 0; i < 8; i++) begin
          repeat (CD) step();
          b[i] = tx;
        end
        if (PAR != 0) begin
          repeat (CD) step();
          if (tx !== ^b) okk = 1'b0;
        end
        repeat (CD) step();
        if (tx !== 1'b1) okk = 1'b0;
        r.b  = b;
        r.ok = okk;
        rx_q.push_back(r);
      end
    end
  end

  initial begin : stimulus
    vec_t        tbl[12];
    logic [31:0] st;
    logic [7:0]  wave[$];
    logic [7:0]  exp_b[$];
    int          e;
    int          first_s;
    int          pe[$];
    logic [7:0]  pb[$];
    int          acc_s[$];
    int          acc_e[$];
    logic [7:0]  acc_b[$];
    bit          dropped;
    int          prev;
    int          lvl;
    bit          popn;
    bit          went_low;

    tbl[0]  = '{BASE + 32'h4,  32'h0,         1'b0, S2,    S2,           1'b1};
    tbl[1]  = '{BASE,          32'h0,         1'b0, 32'h0, S2,           1'b1};
    tbl[2]  = '{BASE + 32'h8,  32'h0,         1'b0, 32'h0, S2,           1'b1};
    tbl[3]  = '{BASE + 32'hC,  32'h41,        1'b1, 32'h0, S2,           1'b1};
    tbl[4]  = '{32'h0,         32'h41,        1'b1, 32'h0, S2,           1'b1};
    tbl[5]  = '{BASE + 32'h4,  32'h41,        1'b1, S2,    S2,           1'b1};
    tbl[6]  = '{32'hFFFE_FFFC, 32'h41,        1'b1, 32'h0, S2,           1'b1};
    tbl[7]  = '{BASE + 32'h8,  32'h0,         1'b1, 32'h0, S2,           1'b1};
    tbl[8]  = '{BASE,          32'h1234_5655, 1'b1, 32'h0, SB | 32'h10,  1'b1};
    tbl[9]  = '{BASE + 32'h4,  32'h0,         1'b0, SB | 32'h10, SB | 32'h10, 1'b1};
    tbl[10] = '{BASE + 32'h8,  32'h1,         1'b1, 32'h0, SB | 32'h10,  1'b1};
    tbl[11] = '{BASE + 32'h4,  32'h0,         1'b0, SB | 32'h10, SB | 32'h06, 1'b0};

    // Reset state, during and after reset.
    repeat (2) step();
    read_status(st);
    check("rst_status", st, S2);
    check("rst_tx", 32'(tx), 32'h1);
    check("rst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    step();
    read_status(st);
    check("post_rst_status", st, S2);

    // Register table: decode, ignored writes, disable/enable.
    for (int i = 0; i < 12; i++) begin
      addr  = tbl[i].addr;
      wdata = tbl[i].wdata;
      we    = tbl[i].we;
      #1;
      check($sformatf("tbl%0d_rdata", i), rdata, tbl[i].exp_rd);
      step();
      read_status(st);
      check($sformatf("tbl%0d_status", i), st, tbl[i].exp_st);
      check($sformatf("tbl%0d_tx", i), 32'(tx), 32'(tbl[i].exp_tx));
    end
    wait_idle(FL + 20, "tbl");
    check("tbl_rx_count", 32'(rx_q.size()), 32'h1);
    if (rx_q.size() > 0) check("tbl_rx_byte", 32'(rx_q[0].b), 32'h55);

    // Single 8'hA5 frame, cycle by cycle.
    rx_q.delete();
    push(32'hA5, e);
    check("a5_tx_before_start", 32'(tx), 32'h1);
    check("a5_busy_on_push", 32'(busy), 32'h1);
    step();
    wave = '{8'hA5};
    check_wave(wave, "a5");
    check("a5_busy_end", 32'(busy), 32'h0);
    check("a5_tx_end", 32'(tx), 32'h1);

    // Back-to-back 8'h00, 8'hFF with no gap.
    push(32'h00, e);
    push(32'hFF, e);
    wave = '{8'h00, 8'hFF};
    check_wave(wave, "b2b");
    check("b2b_busy_end", 32'(busy), 32'h0);

    // Nine rapid stores, then a tenth into a full FIFO.
    rx_q.delete();
    exp_b.delete();
    for (int i = 0; i < 9; i++) begin
      push(32'h10 + 32'(i), e);
      exp_b.push_back(8'(8'h10 + i));
    end
    read_status(st);
    check("burst9_status", st, SB | 32'h85);
    push(32'hEE, e);
    read_status(st);
    check("burst10_overflow", st, SB | 32'h8D);
    write_ctrl(32'h3);
    read_status(st);
    check("burst_clear_ovf", st, SB | 32'h85);
    wait_idle(10 * FL, "burst");
    check("burst_rx_count", 32'(rx_q.size()), 32'd9);
    for (int i = 0; i < 9 && i < rx_q.size(); i++) begin
      check($sformatf("burst_rx%0d_byte", i), 32'(rx_q[i].b), 32'(exp_b[i]));
      check($sformatf("burst_rx%0d_frame", i), 32'(rx_q[i].ok), 32'h1);
      if (i > 0)
        check($sformatf("burst_rx%0d_gap", i), 32'(rx_q[i].s - rx_q[i-1].s), 32'(FL));
    end
    read_status(st);
    check("burst_final_status", st, S2);

    // Randomized stores against a frame-timing model.
    rx_q.delete();
    for (int k = 0; k < 30; k++) begin
      repeat ($urandom_range(0, 10)) step();
      push($urandom, e);
      pe.push_back(e);
      pb.push_back(wdata[7:0]);
    end
    wait_idle(40 * FL, "rand");

    dropped = 1'b0;
    prev    = -100000;
    for (int k = 0; k < pe.size(); k++) begin
      lvl  = 0;
      popn = 1'b0;
      for (int i = 0; i < acc_e.size(); i++) begin
        if (acc_e[i] < pe[k]) lvl++;
        if (acc_s[i] < pe[k]) lvl--;
        if (acc_s[i] == pe[k]) popn = 1'b1;
      end
      if (lvl < DEPTH || popn) begin
        prev = (pe[k] + 1 > prev + FL) ? pe[k] + 1 : prev + FL;
        acc_e.push_back(pe[k]);
        acc_s.push_back(prev);
        acc_b.push_back(pb[k]);
      end else begin
        dropped = 1'b1;
      end
    end
    check("rand_rx_count", 32'(rx_q.size()), 32'(acc_b.size()));
    first_s = (rx_q.size() > 0) ? rx_q[0].s : 0;
    for (int i = 0; i < acc_b.size() && i < rx_q.size(); i++) begin
      check($sformatf("rand_rx%0d_byte", i), 32'(rx_q[i].b), 32'(acc_b[i]));
      check($sformatf("rand_rx%0d_start", i), 32'(rx_q[i].s), 32'(acc_s[i]));
      check($sformatf("rand_rx%0d_frame", i), 32'(rx_q[i].ok), 32'h1);
    end
    read_status(st);
    check("rand_overflow", 32'(st[3]), 32'(dropped));
    write_ctrl(32'h3);

    // Asynchronous reset during data bit 3 of 8'hF0.
    mon_en = 1'b0;
    push(32'hF0, e);
    repeat (18) step();
    check("rst_mid_bit3", 32'(tx), 32'h0);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_mid_tx", 32'(tx), 32'h1);
    check("rst_mid_busy", 32'(busy), 32'h0);
    step();
    step();
    rst_n = 1'b1;
    step();
    read_status(st);
    check("rst_mid_status", st, S2);
    went_low = 1'b0;
    for (int k = 0; k < FL + 8; k++) begin
      if (tx !== 1'b1) went_low = 1'b1;
      step();
    end
    check("rst_no_residual", 32'(went_low), 32'h0);
    check("rst_final_busy", 32'(busy), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop if the sequence ever stalls.
  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "timeout");
  end

endmodule
